inst_queue: RTL and testbench

// - Circular FIFO of fetched instructions between the fetcher and the Decoder/issue stage.
// - Accepts {code, pc} pairs from the fetcher and presents the head entry to the Decoder.
// - Drains on an issue handshake and is cleared wholesale by a ROB mispredict flush.
// - Provides back-pressure to the fetcher through iq_full_out.

---
 rtl/inst_queue.sv | 194 +++++++++++++++++++
 tb/tb_inst_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// Module: inst_queue
//
// Purpose
//   Circular FIFO of fetched instructions sitting between the fetcher and the
//   Decoder/issue stage. The fetcher pushes {code, pc} pairs. The head entry
//   is presented to the Decoder and leaves the queue on an issue handshake.
//   A mispredict flush from the ROB empties the queue in one edge. The full
//   flag gives back-pressure to the fetcher.
//
// Configuration macro
//   IQ_BYPASS_EN : when defined, an instruction arriving at an empty queue is
//                  presented on the head outputs in the same cycle. If issue
//                  accepts it in that cycle, it is consumed without ever
//                  being written. When undefined, there is no
//                  input-to-output combinational path and the minimum
//                  latency is one cycle.
//
// Parameters
//   IQ_DEPTH_LOG   log2 of the entry count (DEPTH = 1 << IQ_DEPTH_LOG)
//
// Ports
//   clk_in          clock, all state updates on posedge
//   rst_in          asynchronous active-low reset
//   rdy_in          global ready; low freezes all state
//   flush_in        mispredict flush from the ROB (priority over all)
//   if_valid_in     fetcher presents an instruction
//   if_code_in      instruction word
//   if_pc_in        pc of that instruction
//   iq_full_out     queue holds DEPTH entries; fetcher must not push
//   iq_valid_out    head entry valid for issue
//   iq_code_out     head code to the Decoder, 0 when not valid
//   iq_pc_out       head pc, 0 when not valid
//   issue_ready_in  issue accepts the head this cycle
//   iq_count_out    number of occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------

`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module inst_queue #(
    parameter int IQ_DEPTH_LOG = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic                     if_valid_in,
    input  logic [`INS_WIDTH-1:0]    if_code_in,
    input  logic [`ADDR_WIDTH-1:0]   if_pc_in,
    output logic                     iq_full_out,
    output logic                     iq_valid_out,
    output logic [`INS_WIDTH-1:0]    iq_code_out,
    output logic [`ADDR_WIDTH-1:0]   iq_pc_out,
    input  logic                     issue_ready_in,
    output logic [IQ_DEPTH_LOG:0]    iq_count_out
);

    localparam int DEPTH = 1 << IQ_DEPTH_LOG;

    localparam logic [IQ_DEPTH_LOG:0]   COUNT_FULL = (IQ_DEPTH_LOG+1)'(DEPTH);
    localparam logic [IQ_DEPTH_LOG:0]   COUNT_ZERO = '0;
    localparam logic [IQ_DEPTH_LOG:0]   COUNT_ONE  = (IQ_DEPTH_LOG+1)'(1);
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ZERO   = '0;
    localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE    = (IQ_DEPTH_LOG)'(1);

    // Pointer and occupancy state. Pointers are plain modulo-DEPTH counters,
    // so wrap-around needs no special case.
    logic [IQ_DEPTH_LOG-1:0] head_q, head_d;
    logic [IQ_DEPTH_LOG-1:0] tail_q, tail_d;
    logic [IQ_DEPTH_LOG:0]   count_q, count_d;

    // Entry storage. It is deliberately not reset. Slots are only ever read
    // when count says they hold live data.
    logic [`INS_WIDTH-1:0]   code_q [DEPTH];
    logic [`ADDR_WIDTH-1:0]  pc_q   [DEPTH];

    logic                    full;
    logic                    stored_valid;
    logic                    push;
    logic                    pop;
    logic                    flush_eff;
    logic                    head_valid;
    logic [`INS_WIDTH-1:0]   head_code;
    logic [`ADDR_WIDTH-1:0]  head_pc;

    // Full is derived purely from registered state. The fetcher therefore
    // never sees a combinational path from issue_ready_in. As a consequence,
    // a push while full is refused even if a pop happens in the same cycle.
    assign full = (count_q == COUNT_FULL);

    // A flush only acts while the pipeline is ready. The ROB holds it until
    // then.
    assign flush_eff = rdy_in & flush_in;

    // The head is valid from stored entries only when ready, occupied and
    // not being flushed.
    assign stored_valid = rdy_in & (count_q != COUNT_ZERO) & ~flush_in;

`ifdef IQ_BYPASS_EN
    logic bypass_hit;

    // On an empty queue the incoming instruction is forwarded directly.
    // If issue takes it this cycle, it never occupies a slot.
    assign bypass_hit = rdy_in & if_valid_in & ~flush_in & (count_q == COUNT_ZERO);

    always_comb begin
        head_valid = stored_valid;
        head_code  = code_q[head_q];
        head_pc    = pc_q[head_q];
        push       = rdy_in & if_valid_in & ~full & ~flush_in;
        pop        = stored_valid & issue_ready_in;
        if (bypass_hit) begin
            head_valid = 1'b1;
            head_code  = if_code_in;
            head_pc    = if_pc_in;
            if (issue_ready_in) begin
                push = 1'b0;
            end
        end
    end
`else
    // Without bypass the head outputs come only from storage, so the
    // minimum latency from push to presentation is one cycle.
    always_comb begin
        head_valid = stored_valid;
        head_code  = code_q[head_q];
        head_pc    = pc_q[head_q];
        push       = rdy_in & if_valid_in & ~full & ~flush_in;
        pop        = stored_valid & issue_ready_in;
    end
`endif

    // Head outputs read as zero when nothing is valid. A zero code is
    // treated as an empty instruction downstream.
    assign iq_valid_out = head_valid;
    assign iq_code_out  = head_valid ? head_code : '0;
    assign iq_pc_out    = head_valid ? head_pc   : '0;
    assign iq_full_out  = full;
    assign iq_count_out = count_q;

    // Next-state computation. A flush overrides any same-cycle push or pop.
    // Push and pop together leave the count unchanged.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_eff) begin
            head_d  = PTR_ZERO;
            tail_d  = PTR_ZERO;
            count_d = COUNT_ZERO;
        end else begin
            if (push) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (pop) begin
                head_d = head_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_d = count_q + COUNT_ONE;
            end else if (pop && !push) begin
                count_d = count_q - COUNT_ONE;
            end
        end
    end

    // Pointer and count registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= PTR_ZERO;
            tail_q  <= PTR_ZERO;
            count_q <= COUNT_ZERO;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry write port. It has no reset so that it maps onto plain
    // storage; push already excludes flush, rdy_in=0 and full.
    always_ff @(posedge clk_in) begin
        if (push) begin
            code_q[tail_q] <= if_code_in;
            pc_q[tail_q]   <= if_pc_in;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// Testbench: tb_inst_queue
//
// Purpose
//   Directed self-checking bench for inst_queue. A single linear initial
//   block drives hand-written vectors and compares the DUT outputs against
//   hand-computed values using immediate assertions.
//
// The bypass step follows the IQ_BYPASS_EN macro, so the bench matches
// whichever build of the queue it is compiled against.
// ---------------------------------------------------------------------------

`ifndef INS_WIDTH
`define INS_WIDTH 32
`endif

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_inst_queue;

    logic                    clk_in;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    flush_in;
    logic                    if_valid_in;
    logic [`INS_WIDTH-1:0]   if_code_in;
    logic [`ADDR_WIDTH-1:0]  if_pc_in;
    logic                    iq_full_out;
    logic                    iq_valid_out;
    logic [`INS_WIDTH-1:0]   iq_code_out;
    logic [`ADDR_WIDTH-1:0]  iq_pc_out;
    logic                    issue_ready_in;
    logic [4:0]              iq_count_out;

    int checkCount;
    int failCount;

    inst_queue #(.IQ_DEPTH_LOG(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_in       (flush_in),
        .if_valid_in    (if_valid_in),
        .if_code_in     (if_code_in),
        .if_pc_in       (if_pc_in),
        .iq_full_out    (iq_full_out),
        .iq_valid_out   (iq_valid_out),
        .iq_code_out    (iq_code_out),
        .iq_pc_out      (iq_pc_out),
        .issue_ready_in (issue_ready_in),
        .iq_count_out   (iq_count_out)
    );

    // Free-running 10-unit clock.
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Drive one cycle's inputs shortly after the rising edge, then let the
    // combinational outputs settle before any check samples them.
    task automatic applyStimulus(input logic valid, input logic [31:0] code,
                                 input logic [31:0] pc, input logic issueRdy,
                                 input logic flush, input logic rdy);
        if_valid_in    = valid;
        if_code_in     = code;
        if_pc_in       = pc;
        issue_ready_in = issueRdy;
        flush_in       = flush;
        rdy_in         = rdy;
        #1;
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst_in     = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset state.
        checkOutput("reset_count", 32'(iq_count_out), 32'd0);
        checkOutput("reset_valid", 32'(iq_valid_out), 32'd0);
        checkOutput("reset_full",  32'(iq_full_out),  32'd0);
        checkOutput("reset_code",  iq_code_out,        32'h0);
        checkOutput("reset_pc",    iq_pc_out,          32'h0);
        tick();
        rst_in = 1'b1;
        tick();

        // Reset mid-stream: fill five entries, then pulse reset asynchronously.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h1 + 32'(i), 32'h10 + 32'(i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("midrst_count_before", 32'(iq_count_out), 32'd5);
        checkOutput("midrst_code_before",  iq_code_out,        32'h1);
        rst_in = 1'b0;
        #1;
        checkOutput("midrst_count", 32'(iq_count_out), 32'd0);
        checkOutput("midrst_valid", 32'(iq_valid_out), 32'd0);
        checkOutput("midrst_code",  iq_code_out,        32'h0);
        rst_in = 1'b1;
        tick();
        applyStimulus(1'b1, 32'hAA, 32'h100, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("postrst_valid", 32'(iq_valid_out), 32'd1);
        checkOutput("postrst_pc",    iq_pc_out,          32'h100);
        checkOutput("postrst_count", 32'(iq_count_out), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("postrst_drained", 32'(iq_count_out), 32'd0);

        // In-order delivery of three instructions.
        applyStimulus(1'b1, 32'h00000013, 32'h200, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h00100093, 32'h204, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h00200113, 32'h208, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("order_count3", 32'(iq_count_out), 32'd3);
        checkOutput("order_code0",  iq_code_out,        32'h00000013);
        tick();
        checkOutput("order_count2", 32'(iq_count_out), 32'd2);
        checkOutput("order_code1",  iq_code_out,        32'h00100093);
        tick();
        checkOutput("order_count1", 32'(iq_count_out), 32'd1);
        checkOutput("order_code2",  iq_code_out,        32'h00200113);
        checkOutput("order_pc2",    iq_pc_out,          32'h208);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("order_count0", 32'(iq_count_out), 32'd0);
        checkOutput("order_valid0", 32'(iq_valid_out), 32'd0);
        checkOutput("order_code_empty", iq_code_out,    32'h0);

        // Full: sixteen pushes, refused push during a pop, then a retry.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h1000 + 32'(i), 32'h400 + 32'(4*i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 32'hDEAD, 32'h500, 1'b1, 1'b0, 1'b1);
        checkOutput("full_flag",  32'(iq_full_out),  32'd1);
        checkOutput("full_count", 32'(iq_count_out), 32'd16);
        checkOutput("full_head",  iq_code_out,        32'h1000);
        tick();
        applyStimulus(1'b1, 32'hDEAD, 32'h500, 1'b0, 1'b0, 1'b1);
        checkOutput("full_refused_count", 32'(iq_count_out), 32'd15);
        checkOutput("full_refused_flag",  32'(iq_full_out),  32'd0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("full_retry_count", 32'(iq_count_out), 32'd16);
        checkOutput("full_retry_flag",  32'(iq_full_out),  32'd1);
        for (int i = 1; i < 16; i++) begin
            checkOutput("full_drain_code", iq_code_out, 32'h1000 + 32'(i));
            tick();
        end
        checkOutput("full_drain_last_code", iq_code_out, 32'hDEAD);
        checkOutput("full_drain_last_pc",   iq_pc_out,   32'h500);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("full_drained", 32'(iq_count_out), 32'd0);

        // Wrap: hold count at three through twenty push/pop pairs.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h600 + 32'(4*i), 32'h600 + 32'(4*i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h60C + 32'(4*i), 32'h60C + 32'(4*i), 1'b1, 1'b0, 1'b1);
            checkOutput("wrap_pc",    iq_pc_out,          32'h600 + 32'(4*i));
            checkOutput("wrap_count", 32'(iq_count_out), 32'd3);
            tick();
        end
        for (int i = 20; i < 23; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
            checkOutput("wrap_tail_pc", iq_pc_out, 32'h600 + 32'(4*i));
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("wrap_drained", 32'(iq_count_out), 32'd0);

        // Flush with a simultaneous push and pop request.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 32'h900 + 32'(i), 32'h900 + 32'(4*i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        applyStimulus(1'b1, 32'hBEEF, 32'hA00, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_count_before", 32'(iq_count_out), 32'd7);
        checkOutput("flush_valid_forced", 32'(iq_valid_out), 32'd0);
        checkOutput("flush_code_forced",  iq_code_out,        32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_count_after", 32'(iq_count_out), 32'd0);
        checkOutput("flush_valid_after", 32'(iq_valid_out), 32'd0);
        checkOutput("flush_pc_after",    iq_pc_out,          32'h0);
        tick();
        checkOutput("flush_no_store", 32'(iq_count_out), 32'd0);

        // rdy_in low freezes everything, including a flush request.
        applyStimulus(1'b1, 32'h700, 32'h700, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 32'h704, 32'h704, 1'b0, 1'b0, 1'b1);
        tick();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b1, 32'hCAFE, 32'hB00, 1'b1, (c >= 2), 1'b0);
            checkOutput("rdy_valid", 32'(iq_valid_out), 32'd0);
            checkOutput("rdy_count", 32'(iq_count_out), 32'd2);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("rdy_head_held",  iq_pc_out,          32'h700);
        checkOutput("rdy_count_held", 32'(iq_count_out), 32'd2);
        tick();
        checkOutput("rdy_tail_held", iq_pc_out,          32'h704);
        checkOutput("rdy_count1",    32'(iq_count_out), 32'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("rdy_drained", 32'(iq_count_out), 32'd0);

        // Push into an empty queue with issue ready: the outcome depends on
        // whether the bypass is built in.
        applyStimulus(1'b1, 32'h00500293, 32'h800, 1'b1, 1'b0, 1'b1);
`ifdef IQ_BYPASS_EN
        checkOutput("bypass_valid", 32'(iq_valid_out), 32'd1);
        checkOutput("bypass_code",  iq_code_out,        32'h00500293);
        checkOutput("bypass_pc",    iq_pc_out,          32'h800);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("bypass_count", 32'(iq_count_out), 32'd0);
`else
        checkOutput("nobypass_valid", 32'(iq_valid_out), 32'd0);
        checkOutput("nobypass_code",  iq_code_out,        32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("nobypass_count", 32'(iq_count_out), 32'd1);
        checkOutput("nobypass_code1", iq_code_out,        32'h00500293);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        checkOutput("nobypass_drained", 32'(iq_count_out), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
